// File: rtl/core_mem_arb.sv
// rtl/core_mem_arb.sv - single memory port arbiter between IFU fetches and LSU loads/stores
// Optional round-robin arbitration between simultaneous requesters: define CORE_MEM_ARB_RR_EN.
module core_mem_arb #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          ifu_req_valid,
   output logic          ifu_req_ready,
   input  logic [AW-1:0] ifu_req_addr,
   output logic          ifu_rsp_valid,
   output logic [DW-1:0] ifu_rsp_data,
   output logic          ifu_rsp_err,
   input  logic          lsu_req_valid,
   output logic          lsu_req_ready,
   input  logic [AW-1:0] lsu_req_addr,
   input  logic          lsu_req_wen,
   input  logic [DW-1:0] lsu_req_wdata,
   input  logic [MW-1:0] lsu_req_wmask,
   output logic          lsu_rsp_valid,
   output logic [DW-1:0] lsu_rsp_data,
   output logic          lsu_rsp_err,
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic [AW-1:0] mem_req_addr,
   output logic          mem_req_wen,
   output logic [DW-1:0] mem_req_wdata,
   output logic [MW-1:0] mem_req_wmask,
   input  logic          mem_rsp_valid,
   input  logic [DW-1:0] mem_rsp_data,
   input  logic          mem_rsp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

   state_t state;
   owner_t owner;
   logic   drop;
   logic   ifu_ok;
   logic   grant_ifu;
   logic   grant_lsu;
   logic   rsp_fire;

   // A flushed fetch is never granted, so a fresh IFU owner never starts out dropped.
   assign ifu_ok = ifu_req_valid & ~flush;

`ifdef CORE_MEM_ARB_RR_EN
   owner_t last_owner;

   always_comb begin
      grant_lsu = 1'b0;
      grant_ifu = 1'b0;
      if (state == IDLE) begin
         if (lsu_req_valid && ifu_ok) begin
            grant_lsu = (last_owner == OWN_IFU);
            grant_ifu = (last_owner == OWN_LSU);
         end else begin
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_ok;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_owner <= OWN_IFU;
      else if (grant_lsu)
         last_owner <= OWN_LSU;
      else if (grant_ifu)
         last_owner <= OWN_IFU;
   end
`else
   assign grant_lsu = (state == IDLE) & lsu_req_valid;
   assign grant_ifu = (state == IDLE) & ifu_ok & ~lsu_req_valid;
`endif

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;

   // A flush in the response cycle itself must also hide the fetch data.
   assign rsp_fire      = (state == RSP) & mem_rsp_valid;
   assign ifu_rsp_valid = rsp_fire & (owner == OWN_IFU) & ~drop & ~flush;
   assign lsu_rsp_valid = rsp_fire & (owner == OWN_LSU);
   assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
   assign ifu_rsp_err   = ifu_rsp_valid & mem_rsp_err;
   assign lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;
   assign lsu_rsp_err   = lsu_rsp_valid & mem_rsp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= OWN_IFU;
         drop          <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_lsu) begin
                  state         <= REQ;
                  owner         <= OWN_LSU;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= lsu_req_addr;
                  mem_req_wen   <= lsu_req_wen;
                  mem_req_wdata <= lsu_req_wdata;
                  mem_req_wmask <= lsu_req_wmask;
               end else if (grant_ifu) begin
                  state         <= REQ;
                  owner         <= OWN_IFU;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= ifu_req_addr;
                  mem_req_wen   <= 1'b0;
                  mem_req_wdata <= '0;
                  mem_req_wmask <= '0;
               end
            end
            REQ: begin
               if (owner == OWN_IFU && flush)
                  drop <= 1'b1;
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= RSP;
               end
            end
            RSP: begin
               if (owner == OWN_IFU && flush)
                  drop <= 1'b1;
               if (mem_rsp_valid) begin
                  drop  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_arb.sv
// tb/tb_core_mem_arb.sv - scoreboard bench for core_mem_arb with a transaction-level reference model
module tb_core_mem_arb;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
`ifdef CORE_MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          ifu_req_valid = 1'b0;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_req_addr = '0;
   logic          ifu_rsp_valid;
   logic [DW-1:0] ifu_rsp_data;
   logic          ifu_rsp_err;
   logic          lsu_req_valid = 1'b0;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_req_addr = '0;
   logic          lsu_req_wen = 1'b0;
   logic [DW-1:0] lsu_req_wdata = '0;
   logic [MW-1:0] lsu_req_wmask = '0;
   logic          lsu_rsp_valid;
   logic [DW-1:0] lsu_rsp_data;
   logic          lsu_rsp_err;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_wen;
   logic [DW-1:0] mem_req_wdata;
   logic [MW-1:0] mem_req_wmask;
   logic          mem_rsp_valid = 1'b0;
   logic [DW-1:0] mem_rsp_data = '0;
   logic          mem_rsp_err = 1'b0;

   always #5 clk = ~clk;

   core_mem_arb #(.AW(AW), .DW(DW), .MW(MW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          wen;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
   } req_t;
   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   req_t req_q[$];
   rsp_t ifu_q[$];
   rsp_t lsu_q[$];
   bit   grant_log[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Reference model: one transaction at a time, tracked as busy/accepted/owner/drop.
   bit m_busy = 0, m_accepted = 0, m_owner_ifu = 0, m_drop = 0, m_last_ifu = 1, just_granted = 0;
   int m_wait = 0;
   int fix_wait = -1;
   bit fix_data = 0, fix_err = 0, spurious_en = 0, log_en = 0;
   logic [DW-1:0] fdata = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_mem(input bit rdy);
      rsp_t r;
      mem_req_ready = rdy;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = fix_data ? fdata : $urandom;
      mem_rsp_err   = fix_data ? fix_err : ($urandom_range(7) == 0);
      if (m_busy && m_accepted) begin
         if (m_wait == 0) begin
            mem_rsp_valid = 1'b1;
            r.data = mem_rsp_data;
            r.err  = mem_rsp_err;
            if (!m_owner_ifu)
               lsu_q.push_back(r);
            else if (!(m_drop || flush))
               ifu_q.push_back(r);
         end else begin
            m_wait--;
         end
      end else if (!m_busy && spurious_en && $urandom_range(3) == 0) begin
         mem_rsp_valid = 1'b1;
      end
   endtask

   task automatic model();
      bit   gi, gl;
      req_t e;
      gi = 0;
      gl = 0;
      if (!m_busy) begin
         if (lsu_req_valid && ifu_req_valid && !flush) begin
            gl = RR ? m_last_ifu : 1'b1;
            gi = !gl;
         end else begin
            gl = lsu_req_valid;
            gi = ifu_req_valid && !flush;
         end
         check("lsu_req_ready", lsu_req_ready, gl);
         check("ifu_req_ready", ifu_req_ready, gi);
         check("mem_req_valid_in_idle", mem_req_valid, 0);
         if (gl || gi) begin
            if (gl) begin
               e.addr = lsu_req_addr; e.wen = lsu_req_wen;
               e.wdata = lsu_req_wdata; e.wmask = lsu_req_wmask;
            end else begin
               e.addr = ifu_req_addr; e.wen = 1'b0; e.wdata = '0; e.wmask = '0;
            end
            req_q.push_back(e);
            if (log_en) grant_log.push_back(ifu_req_ready);
            m_busy = 1; m_accepted = 0; m_owner_ifu = gi; m_drop = 0; m_last_ifu = gi;
            m_wait = (fix_wait >= 0) ? fix_wait : $urandom_range(2);
            just_granted = 1;
         end
      end else begin
         check("lsu_req_ready_busy", lsu_req_ready, 0);
         check("ifu_req_ready_busy", ifu_req_ready, 0);
         if (just_granted) check("mem_req_latency", mem_req_valid, 1);
         just_granted = 0;
         if (m_owner_ifu && flush) m_drop = 1;
         if (!m_accepted && mem_req_valid && mem_req_ready) m_accepted = 1;
         else if (m_accepted && mem_rsp_valid) m_busy = 0;
      end
   endtask

   task automatic tick(input bit iv, input logic [AW-1:0] ia, input bit lv, input logic [AW-1:0] la,
                       input bit lw, input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                       input bit fl, input bit rdy);
      @(posedge clk);
      #1;
      ifu_req_valid = iv; ifu_req_addr = ia;
      lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = lw;
      lsu_req_wdata = wd; lsu_req_wmask = wm;
      flush = fl;
      drive_mem(rdy);
      @(negedge clk);
      model();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) tick(0, '0, 0, '0, 0, '0, '0, 0, rdy);
   endtask

   always @(negedge clk) begin
      rsp_t r;
      if (mon_en) begin
         if (req_q.size() > 0 && mem_req_valid) begin
            check("mem_req_addr", mem_req_addr, req_q[0].addr);
            check("mem_req_wen", mem_req_wen, req_q[0].wen);
            check("mem_req_wdata", mem_req_wdata, req_q[0].wdata);
            check("mem_req_wmask", mem_req_wmask, req_q[0].wmask);
            if (mem_req_ready) void'(req_q.pop_front());
         end else if (req_q.size() == 0) begin
            check("mem_req_valid_unexpected", mem_req_valid, 0);
         end
         if (ifu_q.size() > 0) begin
            r = ifu_q.pop_front();
            check("ifu_rsp_valid", ifu_rsp_valid, 1);
            check("ifu_rsp_data", ifu_rsp_data, r.data);
            check("ifu_rsp_err", ifu_rsp_err, r.err);
         end else begin
            check("ifu_rsp_valid_unexpected", ifu_rsp_valid, 0);
            check("ifu_rsp_data_idle", ifu_rsp_data, 0);
            check("ifu_rsp_err_idle", ifu_rsp_err, 0);
         end
         if (lsu_q.size() > 0) begin
            r = lsu_q.pop_front();
            check("lsu_rsp_valid", lsu_rsp_valid, 1);
            check("lsu_rsp_data", lsu_rsp_data, r.data);
            check("lsu_rsp_err", lsu_rsp_err, r.err);
         end else begin
            check("lsu_rsp_valid_unexpected", lsu_rsp_valid, 0);
            check("lsu_rsp_data_idle", lsu_rsp_data, 0);
            check("lsu_rsp_err_idle", lsu_rsp_err, 0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_mem_req_wen", mem_req_wen, 0);
      check("rst_mem_req_wdata", mem_req_wdata, 0);
      check("rst_mem_req_wmask", mem_req_wmask, 0);
      check("rst_ifu_req_ready", ifu_req_ready, 0);
      check("rst_lsu_req_ready", lsu_req_ready, 0);
      check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
      check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
      check("rst_rsp_err", {ifu_rsp_err, lsu_rsp_err}, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      fix_wait = 0;

      // Contention right after reset: last owner starts as IFU.
      log_en = 1;
      for (int i = 0; i < 14; i++)
         tick(1, 32'h0000_1000 + 32'(i * 4), 1, 32'h0000_2000 + 32'(i * 4), 0, '0, '0, 0, 1);
      log_en = 0;
      idle(2, 1);
      check("contention_grant_count", grant_log.size() >= 4, 1);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check("contention_grant_is_ifu", grant_log[k], RR ? (k % 2) : 0);

      // Single fetch: ready on the first REQ cycle, response one cycle later.
      fix_data = 1; fdata = 32'h0000_0013; fix_err = 0;
      tick(1, 32'h8000_0000, 0, '0, 0, '0, '0, 0, 1);
      idle(4, 1);

      // Store held off by the memory for three cycles.
      fdata = 32'h0;
      tick(0, '0, 1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, '0, 0, '0, 0, '0, '0, 0, 0);
      idle(4, 1);

      // Flush during RSP drops an IFU response but never an LSU one.
      fdata = 32'h1234_5678; fix_wait = 1;
      tick(1, 32'h8000_0040, 0, '0, 0, '0, '0, 0, 1);
      tick(0, '0, 0, '0, 0, '0, '0, 0, 1);
      tick(0, '0, 0, '0, 0, '0, '0, 1, 1);
      idle(3, 1);
      tick(0, '0, 1, 32'h8000_0080, 0, '0, '0, 0, 1);
      tick(0, '0, 0, '0, 0, '0, '0, 0, 1);
      tick(0, '0, 0, '0, 0, '0, '0, 1, 1);
      idle(3, 1);
      fix_wait = 0;

      // Bus error on an LSU load.
      fdata = 32'hCAFE_0001; fix_err = 1;
      tick(0, '0, 1, 32'h8000_0200, 0, '0, '0, 0, 1);
      idle(4, 1);
      fix_data = 0; fix_err = 0;

      // Randomized traffic with random flushes, stalls and stray responses.
      fix_wait = -1; spurious_en = 1;
      for (int i = 0; i < 600; i++)
         tick($urandom_range(99) < 55, $urandom & 32'hFFFF_FFFC, $urandom_range(99) < 45,
              $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
              $urandom_range(99) < 15, $urandom_range(99) < 60);
      spurious_en = 0; fix_wait = 0;
      idle(8, 1);

      // Reset while a request is waiting in REQ.
      tick(0, '0, 1, 32'h8000_0300, 0, '0, '0, 0, 0);
      tick(0, '0, 0, '0, 0, '0, '0, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_req_valid", mem_req_valid, 0);
      check("reset_mid_lsu_rsp", lsu_rsp_valid, 0);
      req_q.delete(); ifu_q.delete(); lsu_q.delete();
      m_busy = 0; m_accepted = 0; m_drop = 0; m_last_ifu = 1; just_granted = 0;
      idle(2, 1);
      rst_n = 1'b1;
      tick(0, '0, 1, 32'h8000_0400, 0, '0, '0, 0, 1);
      idle(4, 1);
      check("post_reset_queues_drained", req_q.size() + ifu_q.size() + lsu_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
